// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse encoder: FSM states, character codes,
// element timing in units and the ROM entry layout.
package morse_pkg;

   localparam int PAT_W = 6;

   typedef enum logic [2:0] {IDLE, MARK, GAP, CHAR_GAP, WORD_GAP} state_t;

   localparam logic [5:0] CODE_LETTER_A   = 6'd0;
   localparam logic [5:0] CODE_DIGIT_0    = 6'd26;
   localparam logic [5:0] CODE_WORD_SPACE = 6'd36;
   localparam logic [5:0] CODE_PERIOD     = 6'd37;
   localparam logic [5:0] CODE_COMMA      = 6'd38;
   localparam logic [5:0] CODE_QUERY      = 6'd39;

   localparam int DOT_UNITS      = 1;
   localparam int DASH_UNITS     = 3;
   localparam int GAP_UNITS      = 1;
   localparam int CHAR_GAP_UNITS = 3;
   localparam int WORD_GAP_UNITS = 4;

   typedef struct packed {
      logic             valid;
      logic [2:0]       len;
      logic [PAT_W-1:0] pat;
   } rom_entry_t;

   // seq is written in sending order, left-aligned (bit 5 = first element, 1 = dash);
   // the stored pattern is reversed so that bit 0 is the first element.
   function automatic rom_entry_t mk(input logic [2:0] len, input logic [PAT_W-1:0] seq);
      rom_entry_t e;
      e.valid = 1'b1;
      e.len   = len;
      e.pat   = {<<{seq}};
      return e;
   endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational character-code to Morse pattern lookup.
// Punctuation entries (codes 37-39) exist only when MORSE_ENCODER_PUNCT_EN is defined.
module morse_rom
   import morse_pkg::*;
(
   input  logic [5:0] code,
   output rom_entry_t entry
);

   always_comb begin
      entry = '0;
      case (code)
         6'd0:  entry = mk(3'd2, 6'b010000); // A
         6'd1:  entry = mk(3'd4, 6'b100000); // B
         6'd2:  entry = mk(3'd4, 6'b101000); // C
         6'd3:  entry = mk(3'd3, 6'b100000); // D
         6'd4:  entry = mk(3'd1, 6'b000000); // E
         6'd5:  entry = mk(3'd4, 6'b001000);
         6'd6:  entry = mk(3'd3, 6'b110000);
         6'd7:  entry = mk(3'd4, 6'b000000);
         6'd8:  entry = mk(3'd2, 6'b000000);
         6'd9:  entry = mk(3'd4, 6'b011100);
         6'd10: entry = mk(3'd3, 6'b101000);
         6'd11: entry = mk(3'd4, 6'b010000);
         6'd12: entry = mk(3'd2, 6'b110000);
         6'd13: entry = mk(3'd2, 6'b100000);
         6'd14: entry = mk(3'd3, 6'b111000);
         6'd15: entry = mk(3'd4, 6'b011000);
         6'd16: entry = mk(3'd4, 6'b110100); // Q
         6'd17: entry = mk(3'd3, 6'b010000);
         6'd18: entry = mk(3'd3, 6'b000000);
         6'd19: entry = mk(3'd1, 6'b100000); // T
         6'd20: entry = mk(3'd3, 6'b001000);
         6'd21: entry = mk(3'd4, 6'b000100);
         6'd22: entry = mk(3'd3, 6'b011000);
         6'd23: entry = mk(3'd4, 6'b100100);
         6'd24: entry = mk(3'd4, 6'b101100);
         6'd25: entry = mk(3'd4, 6'b110000); // Z
         6'd26: entry = mk(3'd5, 6'b111110); // 0
         6'd27: entry = mk(3'd5, 6'b011110);
         6'd28: entry = mk(3'd5, 6'b001110);
         6'd29: entry = mk(3'd5, 6'b000110);
         6'd30: entry = mk(3'd5, 6'b000010);
         6'd31: entry = mk(3'd5, 6'b000000);
         6'd32: entry = mk(3'd5, 6'b100000);
         6'd33: entry = mk(3'd5, 6'b110000);
         6'd34: entry = mk(3'd5, 6'b111000);
         6'd35: entry = mk(3'd5, 6'b111100); // 9
`ifdef MORSE_ENCODER_PUNCT_EN
         CODE_PERIOD: entry = mk(3'd6, 6'b010101);
         CODE_COMMA:  entry = mk(3'd6, 6'b110011);
         CODE_QUERY:  entry = mk(3'd6, 6'b001100);
`endif
         default: entry = '0;
      endcase
   end

endmodule

// File: rtl/morse_encoder.sv
// Morse keyer: accepts one character code at a time and keys it out on key_out,
// timed in units of UNIT_TICKS tick pulses. Punctuation via MORSE_ENCODER_PUNCT_EN.
module morse_encoder
   import morse_pkg::*;
#(
   parameter int UNIT_TICKS = 1
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       tick,
   input  logic       char_valid,
   input  logic [5:0] char_code,
   output logic       char_ready,
   output logic       key_out,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [7:0] LAST_TICK = 8'(UNIT_TICKS - 1);

   state_t           state;
   logic [7:0]       tick_cnt;
   logic [1:0]       unit_cnt;
   logic [PAT_W-1:0] pat;
   logic [2:0]       len;
   logic [2:0]       idx;
   logic [1:0]       last_unit;
   logic             unit_done;
   logic             phase_done;
   rom_entry_t       rom;

   morse_rom u_rom (
      .code  (char_code),
      .entry (rom)
   );

   always_comb begin
      last_unit = 2'd0;
      case (state)
         MARK:     last_unit = pat[idx] ? 2'(DASH_UNITS - 1) : 2'(DOT_UNITS - 1);
         GAP:      last_unit = 2'(GAP_UNITS - 1);
         CHAR_GAP: last_unit = 2'(CHAR_GAP_UNITS - 1);
         WORD_GAP: last_unit = 2'(WORD_GAP_UNITS - 1);
         default:  last_unit = 2'd0;
      endcase
   end

   assign unit_done  = tick && (tick_cnt == LAST_TICK);
   assign phase_done = unit_done && (unit_cnt == last_unit);
   assign busy       = ~char_ready;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state      <= IDLE;
         key_out    <= 1'b0;
         char_ready <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         tick_cnt   <= '0;
         unit_cnt   <= '0;
         pat        <= '0;
         len        <= '0;
         idx        <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         // Ordinary counting; every state change below overrides this with a clear,
         // which also discards a tick landing on the transition edge.
         if (state != IDLE) begin
            if (unit_done) begin
               tick_cnt <= '0;
               unit_cnt <= unit_cnt + 2'd1;
            end else if (tick) begin
               tick_cnt <= tick_cnt + 8'd1;
            end
         end
         case (state)
            IDLE: begin
               if (char_valid) begin
                  tick_cnt <= '0;
                  unit_cnt <= '0;
                  if (char_code == CODE_WORD_SPACE) begin
                     state      <= WORD_GAP;
                     char_ready <= 1'b0;
                  end else if (rom.valid) begin
                     state      <= MARK;
                     key_out    <= 1'b1;
                     char_ready <= 1'b0;
                     pat        <= rom.pat;
                     len        <= rom.len;
                     idx        <= '0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            MARK: begin
               if (phase_done) begin
                  tick_cnt <= '0;
                  unit_cnt <= '0;
                  key_out  <= 1'b0;
                  state    <= (idx == len - 3'd1) ? CHAR_GAP : GAP;
               end
            end
            GAP: begin
               if (phase_done) begin
                  tick_cnt <= '0;
                  unit_cnt <= '0;
                  key_out  <= 1'b1;
                  idx      <= idx + 3'd1;
                  state    <= MARK;
               end
            end
            CHAR_GAP, WORD_GAP: begin
               if (phase_done) begin
                  tick_cnt   <= '0;
                  unit_cnt   <= '0;
                  state      <= IDLE;
                  char_ready <= 1'b1;
                  done       <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder: one instance with UNIT_TICKS=1, one with UNIT_TICKS=3,
// sharing stimulus; key_out is traced per cycle and compared to hand-derived patterns.
module tb_morse_encoder;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       tick = 1'b0;
   logic       char_valid = 1'b0;
   logic [5:0] char_code = 6'd0;

   logic ready1, key1, busy1, done1, err1;
   logic ready3, key3, busy3, done3, err3;
   logic o_ready, o_key, o_busy, o_done, o_err;
   bit   sel = 1'b0;

   int errors = 0;
   int checks = 0;
   int div = 1;
   int phase = 0;

   logic [63:0] trace;
   int          tlen;
   int          runs[$];
   bit          saw_err;
   bit          saw_done;

   morse_encoder #(.UNIT_TICKS(1)) u_dut1 (
      .CLK(CLK), .RST_N(RST_N), .tick(tick), .char_valid(char_valid), .char_code(char_code),
      .char_ready(ready1), .key_out(key1), .busy(busy1), .done(done1), .err(err1)
   );

   morse_encoder #(.UNIT_TICKS(3)) u_dut3 (
      .CLK(CLK), .RST_N(RST_N), .tick(tick), .char_valid(char_valid), .char_code(char_code),
      .char_ready(ready3), .key_out(key3), .busy(busy3), .done(done3), .err(err3)
   );

   assign o_ready = sel ? ready3 : ready1;
   assign o_key   = sel ? key3   : key1;
   assign o_busy  = sel ? busy3  : busy1;
   assign o_done  = sel ? done3  : done1;
   assign o_err   = sel ? err3   : err1;

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Outputs are sampled at the falling edge; tick for the next rising edge is set here.
   task automatic clk1();
      @(negedge CLK);
      tick  = (phase == 0);
      phase = (phase + 1) % div;
   endtask

   task automatic send(input logic [5:0] code, input bit noise);
      int   guard;
      int   run;
      logic prev;
      clk1();
      guard = 0;
      while (!tick && guard < 16) begin
         clk1();
         guard++;
      end
      char_valid = 1'b1;
      char_code  = code;
      clk1();
      char_valid = 1'b0;
      trace = '0;
      tlen  = 0;
      runs.delete();
      saw_err  = o_err;
      saw_done = 1'b0;
      run   = 0;
      prev  = 1'b0;
      if (saw_err) return;
      guard = 0;
      while (!o_done && guard < 2000) begin
         trace = {trace[62:0], o_key};
         tlen++;
         if (tlen > 1 && o_key != prev) begin
            runs.push_back(run);
            run = 0;
         end
         run++;
         prev = o_key;
         if (noise) begin
            char_valid = 1'b1;
            char_code  = 6'($urandom_range(0, 63));
         end
         clk1();
         guard++;
      end
      char_valid = 1'b0;
      if (run > 0) runs.push_back(run);
      saw_done = o_done;
      if (guard >= 2000) chk("done_timeout", 64'(guard), 64'd0);
   endtask

   initial begin
      int cnt_done;
      int cnt_err;
      int cnt_key;
      int exp_runs[10];
      int obs;

      RST_N = 1'b0;
      repeat (3) clk1();
      chk("rst_state", {59'd0, o_ready, o_busy, o_key, o_done, o_err}, 64'b10000);
      chk("rst_state3", {59'd0, ready3, busy3, key3, done3, err3}, 64'b10000);
      RST_N = 1'b1;
      clk1();

      // 'E': 1 unit mark, 3 units char gap
      send(6'd4, 1'b0);
      chk("E_len", 64'(tlen), 64'd4);
      chk("E_trace", trace, 64'h8);
      chk("E_done_rdy_busy", {61'd0, o_done, o_ready, o_busy}, 64'b110);
      clk1();
      chk("E_done_pulse", {63'd0, o_done}, 64'd0);

      // 'A': .- => 1,0,1,1,1,0,0,0
      send(6'd0, 1'b0);
      chk("A_len", 64'(tlen), 64'd8);
      chk("A_trace", trace, 64'hB8);

      // 'E' again with garbage on the inputs while busy
      send(6'd4, 1'b1);
      chk("E_noise_len", 64'(tlen), 64'd4);
      chk("E_noise_trace", trace, 64'h8);
      clk1();
      clk1();
      chk("E_noise_idle", {62'd0, o_ready, o_key}, 64'b10);

      // 'Q': --.- then char gap
      send(6'd16, 1'b0);
      chk("Q_len", 64'(tlen), 64'd16);
      chk("Q_trace", trace, 64'hEEB8);

      // word space: 4 silent units
      send(6'd36, 1'b0);
      chk("WS_len", 64'(tlen), 64'd4);
      chk("WS_trace", trace, 64'h0);
      chk("WS_done", {63'd0, saw_done}, 64'd1);

      // invalid code 45
      clk1();
      char_valid = 1'b1;
      char_code  = 6'd45;
      clk1();
      char_valid = 1'b0;
      chk("inv_err_rdy_key", {61'd0, o_err, o_ready, o_key}, 64'b110);
      cnt_done = 0; cnt_err = 0; cnt_key = 0;
      repeat (8) begin
         clk1();
         cnt_done += int'(o_done);
         cnt_err  += int'(o_err);
         cnt_key  += int'(o_key);
      end
      chk("inv_after_done", 64'(cnt_done), 64'd0);
      chk("inv_after_err", 64'(cnt_err), 64'd0);
      chk("inv_after_key", 64'(cnt_key), 64'd0);

      // code 37: punctuation or invalid depending on build
      send(6'd37, 1'b0);
`ifdef MORSE_ENCODER_PUNCT_EN
      chk("P_len", 64'(tlen), 64'd20);
      chk("P_trace", trace, 64'hBAEB8);
`else
      chk("P_err", {63'd0, saw_err}, 64'd1);
      chk("P_rdy_key", {62'd0, o_ready, o_key}, 64'b10);
`endif

      // reset in the middle of the dash of 'T'
      clk1();
      char_valid = 1'b1;
      char_code  = 6'd19;
      clk1();
      char_valid = 1'b0;
      clk1();
      chk("T_mid_key", {63'd0, o_key}, 64'd1);
      RST_N = 1'b0;
      clk1();
      RST_N = 1'b1;
      chk("T_rst_key_rdy_busy", {61'd0, o_key, o_ready, o_busy}, 64'b010);
      cnt_done = 0;
      repeat (8) begin
         clk1();
         cnt_done += int'(o_done);
      end
      chk("T_rst_no_done", 64'(cnt_done), 64'd0);

      // '0' on the UNIT_TICKS=3 instance, tick every 4th cycle
      RST_N = 1'b0;
      clk1();
      clk1();
      RST_N = 1'b1;
      div   = 4;
      phase = 0;
      sel   = 1'b1;
      send(6'd26, 1'b0);
      exp_runs = '{36, 12, 36, 12, 36, 12, 36, 12, 36, 36};
      chk("Z0_nruns", 64'(runs.size()), 64'd10);
      for (int i = 0; i < 10; i++) begin
         obs = (i < runs.size()) ? runs[i] : 0;
         chk($sformatf("Z0_run%0d", i), 64'(obs), 64'(exp_runs[i]));
      end
      chk("Z0_done", {63'd0, saw_done}, 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
